sal_bank_ctrl: RTL and testbench

Per-bank DRAM controller that sits directly downstream of the address decoder: it consumes one bank request (row, column, burst length, direction) at a time over a valid/ready handshake. It tracks the bank's open row and enforces the per-bank timing constraints tRCD, tRAS, tRP, tRTP and tWR. It then requests ACT, RD, WR and PRE commands from the channel scheduler over a valid/grant handshake. One instance is built per bank.

---
 rtl/sal_pkg.sv | 33 +++
 rtl/sal_tcnt.sv | 31 +++
 rtl/sal_bank_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_sal_bank_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sal_pkg.sv
// Shared types and default DRAM bank timing for the sal bank controller.
// These defaults are kept in step with the DDR timing parameters header.
package sal_pkg;

    typedef enum logic [1:0] {
        CMD_ACT = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2,
        CMD_PRE = 2'd3
    } cmd_type_t;

    typedef enum logic [1:0] {
        BK_CLOSED  = 2'd0,
        BK_OPEN    = 2'd1,
        BK_CLOSING = 2'd2
    } bk_state_t;

    localparam int unsigned SAL_T_RCD = 32'd4;
    localparam int unsigned SAL_T_RAS = 32'd12;
    localparam int unsigned SAL_T_RP  = 32'd4;
    localparam int unsigned SAL_T_RTP = 32'd3;
    localparam int unsigned SAL_T_WR  = 32'd6;

    function automatic int unsigned tmax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counters hold at most T-1, so $clog2(T) bits suffice (never fewer than one).
    function automatic int unsigned cnt_width(input int unsigned t_max);
        return (t_max <= 32'd2) ? 32'd1 : $clog2(t_max);
    endfunction

endpackage

// File: rtl/sal_tcnt.sv
// Loadable saturating down-counter used for one per-bank timing constraint.
module sal_tcnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         is_zero
);

    logic [W-1:0] value_r;

    // Reload has priority; otherwise count down and stick at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= {W{1'b0}};
        end else if (load) begin
            value_r <= load_val;
        end else if (value_r != {W{1'b0}}) begin
            value_r <= value_r - W'(1);
        end else begin
            value_r <= value_r;
        end
    end

    assign value   = value_r;
    assign is_zero = (value_r == {W{1'b0}});

endmodule

// File: rtl/sal_bank_ctrl.sv
// Per-bank DRAM controller: one pending request, open-row tracking, ACT/RD/WR/PRE timing.
// Page policy: define SAL_BK_OPEN_PAGE_EN for open-page, otherwise closed-page.
module sal_bank_ctrl
    import sal_pkg::*;
#(
    parameter int unsigned ID_W  = 4,
    parameter int unsigned RA_W  = 14,
    parameter int unsigned CA_W  = 10,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned T_RCD = SAL_T_RCD,
    parameter int unsigned T_RAS = SAL_T_RAS,
    parameter int unsigned T_RP  = SAL_T_RP,
    parameter int unsigned T_RTP = SAL_T_RTP,
    parameter int unsigned T_WR  = SAL_T_WR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ID_W-1:0]  req_id,
    input  logic [RA_W-1:0]  req_ra,
    input  logic [CA_W-1:0]  req_ca,
    input  logic [LEN_W-1:0] req_len,
    input  logic             req_wr,
    output logic             cmd_valid,
    output logic [1:0]       cmd_type,
    input  logic             cmd_gnt,
    output logic [ID_W-1:0]  cmd_id,
    output logic [RA_W-1:0]  cmd_ra,
    output logic [CA_W-1:0]  cmd_ca,
    output logic [LEN_W-1:0] cmd_len,
    output logic             row_open,
    output logic [RA_W-1:0]  open_ra
);

    localparam int unsigned T_MAX = tmax(tmax(tmax(T_RCD, T_RAS), tmax(T_RP, T_RTP)), T_WR);
    localparam int unsigned CNT_W = cnt_width(T_MAX);

    bk_state_t        state_r;
    logic             pend_valid_r;
    logic             req_ready_r;
    logic [ID_W-1:0]  pend_id_r;
    logic [RA_W-1:0]  pend_ra_r;
    logic [CA_W-1:0]  pend_ca_r;
    logic [LEN_W-1:0] pend_len_r;
    logic             pend_wr_r;

    logic             cmd_valid_r;
    cmd_type_t        cmd_type_r;
    logic [ID_W-1:0]  cmd_id_r;
    logic [RA_W-1:0]  cmd_ra_r;
    logic [CA_W-1:0]  cmd_ca_r;
    logic [LEN_W-1:0] cmd_len_r;
    logic             row_open_r;
    logic [RA_W-1:0]  open_ra_r;

    logic             grant_s;
    logic             ld_rcd_s, ld_ras_s, ld_rp_s, ld_rtp_s, ld_wr_s;
    logic [CNT_W-1:0] rcd_val_s, ras_val_s, rp_val_s, rtp_val_s, wr_val_s;
    logic             rcd_zero_s, ras_zero_s, rp_zero_s, rtp_zero_s, wr_zero_s;
    logic             rcd_ok_s, ras_ok_s, rp_ok_s, rtp_ok_s, wr_ok_s;
    logic             row_hit_s;

    // Counter reloads are driven by the grant of the command that starts each constraint
    always_comb begin
        grant_s  = cmd_valid_r && cmd_gnt;
        ld_rcd_s = 1'b0;
        ld_ras_s = 1'b0;
        ld_rp_s  = 1'b0;
        ld_rtp_s = 1'b0;
        ld_wr_s  = 1'b0;
        if (grant_s) begin
            case (cmd_type_r)
                CMD_ACT: begin
                    ld_rcd_s = 1'b1;
                    ld_ras_s = 1'b1;
                end
                CMD_RD:  ld_rtp_s = 1'b1;
                CMD_WR:  ld_wr_s  = 1'b1;
                CMD_PRE: ld_rp_s  = 1'b1;
                default: ld_rp_s  = 1'b0;
            endcase
        end else begin
            ld_rcd_s = 1'b0;
        end
    end

    sal_tcnt #(.W(CNT_W)) u_trcd (.clk(clk), .rst(rst), .load(ld_rcd_s),
        .load_val(CNT_W'(T_RCD - 32'd1)), .value(rcd_val_s), .is_zero(rcd_zero_s));
    sal_tcnt #(.W(CNT_W)) u_tras (.clk(clk), .rst(rst), .load(ld_ras_s),
        .load_val(CNT_W'(T_RAS - 32'd1)), .value(ras_val_s), .is_zero(ras_zero_s));
    sal_tcnt #(.W(CNT_W)) u_trp  (.clk(clk), .rst(rst), .load(ld_rp_s),
        .load_val(CNT_W'(T_RP - 32'd1)),  .value(rp_val_s),  .is_zero(rp_zero_s));
    sal_tcnt #(.W(CNT_W)) u_trtp (.clk(clk), .rst(rst), .load(ld_rtp_s),
        .load_val(CNT_W'(T_RTP - 32'd1)), .value(rtp_val_s), .is_zero(rtp_zero_s));
    sal_tcnt #(.W(CNT_W)) u_twr  (.clk(clk), .rst(rst), .load(ld_wr_s),
        .load_val(CNT_W'(T_WR - 32'd1)),  .value(wr_val_s),  .is_zero(wr_zero_s));

    // cmd_valid is registered, so legality is judged on the counter value of the next cycle
    assign rcd_ok_s  = rcd_zero_s || (rcd_val_s == CNT_W'(1));
    assign ras_ok_s  = ras_zero_s || (ras_val_s == CNT_W'(1));
    assign rp_ok_s   = rp_zero_s  || (rp_val_s  == CNT_W'(1));
    assign rtp_ok_s  = rtp_zero_s || (rtp_val_s == CNT_W'(1));
    assign wr_ok_s   = wr_zero_s  || (wr_val_s  == CNT_W'(1));
    assign row_hit_s = (pend_ra_r == open_ra_r);

    // Request capture, bank state machine and registered command outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= BK_CLOSED;
            pend_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            pend_id_r    <= {ID_W{1'b0}};
            pend_ra_r    <= {RA_W{1'b0}};
            pend_ca_r    <= {CA_W{1'b0}};
            pend_len_r   <= {LEN_W{1'b0}};
            pend_wr_r    <= 1'b0;
            cmd_valid_r  <= 1'b0;
            cmd_type_r   <= CMD_ACT;
            cmd_id_r     <= {ID_W{1'b0}};
            cmd_ra_r     <= {RA_W{1'b0}};
            cmd_ca_r     <= {CA_W{1'b0}};
            cmd_len_r    <= {LEN_W{1'b0}};
            row_open_r   <= 1'b0;
            open_ra_r    <= {RA_W{1'b0}};
        end else begin
            if (req_valid && req_ready_r) begin
                pend_valid_r <= 1'b1;
                req_ready_r  <= 1'b0;
                pend_id_r    <= req_id;
                pend_ra_r    <= req_ra;
                pend_ca_r    <= req_ca;
                pend_len_r   <= req_len;
                pend_wr_r    <= req_wr;
            end
            case (state_r)
                BK_CLOSED: begin
                    if (cmd_valid_r) begin
                        if (cmd_gnt) begin
                            cmd_valid_r <= 1'b0;
                            state_r     <= BK_OPEN;
                            row_open_r  <= 1'b1;
                            open_ra_r   <= pend_ra_r;
                        end
                    end else if (pend_valid_r && rp_ok_s) begin
                        cmd_valid_r <= 1'b1;
                        cmd_type_r  <= CMD_ACT;
                        cmd_id_r    <= pend_id_r;
                        cmd_ra_r    <= pend_ra_r;
                        cmd_ca_r    <= pend_ca_r;
                        cmd_len_r   <= pend_len_r;
                    end
                end
                BK_OPEN: begin
                    if (cmd_valid_r) begin
                        if (cmd_gnt) begin
                            cmd_valid_r  <= 1'b0;
                            pend_valid_r <= 1'b0;
                            req_ready_r  <= 1'b1;
`ifdef SAL_BK_OPEN_PAGE_EN
                            state_r      <= BK_OPEN;
`else
                            state_r      <= BK_CLOSING;
`endif
                        end
                    end else if (pend_valid_r) begin
                        if (!row_hit_s) begin
                            state_r <= BK_CLOSING;
                        end else if (rcd_ok_s) begin
                            cmd_valid_r <= 1'b1;
                            cmd_type_r  <= pend_wr_r ? CMD_WR : CMD_RD;
                            cmd_id_r    <= pend_id_r;
                            cmd_ra_r    <= pend_ra_r;
                            cmd_ca_r    <= pend_ca_r;
                            cmd_len_r   <= pend_len_r;
                        end
                    end
                end
                BK_CLOSING: begin
                    if (cmd_valid_r) begin
                        if (cmd_gnt) begin
                            cmd_valid_r <= 1'b0;
                            state_r     <= BK_CLOSED;
                            row_open_r  <= 1'b0;
                        end
                    end else if (ras_ok_s && rtp_ok_s && wr_ok_s) begin
                        cmd_valid_r <= 1'b1;
                        cmd_type_r  <= CMD_PRE;
                        cmd_id_r    <= pend_id_r;
                        cmd_ra_r    <= open_ra_r;
                        cmd_ca_r    <= pend_ca_r;
                        cmd_len_r   <= pend_len_r;
                    end
                end
                default: begin
                    state_r     <= BK_CLOSED;
                    cmd_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates ready directly so it reads 0 during reset and 1 the cycle after
    assign req_ready = req_ready_r && !rst;
    assign cmd_valid = cmd_valid_r;
    assign cmd_type  = cmd_type_r;
    assign cmd_id    = cmd_id_r;
    assign cmd_ra    = cmd_ra_r;
    assign cmd_ca    = cmd_ca_r;
    assign cmd_len   = cmd_len_r;
    assign row_open  = row_open_r;
    assign open_ra   = open_ra_r;

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Directed bench for sal_bank_ctrl: reset, ACT/RD/WR/PRE spacing, grant hold, reset abort.
// Follows the page policy selected by SAL_BK_OPEN_PAGE_EN, like the design.
module tb_sal_bank_ctrl;

    localparam int unsigned ID_W  = 4;
    localparam int unsigned RA_W  = 14;
    localparam int unsigned CA_W  = 10;
    localparam int unsigned LEN_W = 4;
    localparam int T_RCD = 4;
    localparam int T_RAS = 12;
    localparam int T_RP  = 4;
    localparam int T_RTP = 3;
    localparam int T_WR  = 6;

    localparam logic [1:0] ACT = 2'd0;
    localparam logic [1:0] RD  = 2'd1;
    localparam logic [1:0] WR  = 2'd2;
    localparam logic [1:0] PRE = 2'd3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [ID_W-1:0]  req_id;
    logic [RA_W-1:0]  req_ra;
    logic [CA_W-1:0]  req_ca;
    logic [LEN_W-1:0] req_len;
    logic             req_wr;
    logic             cmd_valid;
    logic [1:0]       cmd_type;
    logic             cmd_gnt;
    logic [ID_W-1:0]  cmd_id;
    logic [RA_W-1:0]  cmd_ra;
    logic [CA_W-1:0]  cmd_ca;
    logic [LEN_W-1:0] cmd_len;
    logic             row_open;
    logic [RA_W-1:0]  open_ra;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    sal_bank_ctrl #(
        .ID_W(ID_W), .RA_W(RA_W), .CA_W(CA_W), .LEN_W(LEN_W),
        .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP), .T_RTP(T_RTP), .T_WR(T_WR)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_ra(req_ra),
        .req_ca(req_ca), .req_len(req_len), .req_wr(req_wr),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_gnt(cmd_gnt), .cmd_id(cmd_id),
        .cmd_ra(cmd_ra), .cmd_ca(cmd_ca), .cmd_len(cmd_len),
        .row_open(row_open), .open_ra(open_ra)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_req(input string tag, input int id, input int ra, input int ca,
                            input int len, input logic wr, output int acc);
        req_valid = 1'b1;
        req_id    = ID_W'(id);
        req_ra    = RA_W'(ra);
        req_ca    = CA_W'(ca);
        req_len   = LEN_W'(len);
        req_wr    = wr;
        #0;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        acc = cyc;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_cmd(input string tag, input logic [1:0] typ, output int at);
        int n = 0;
        while (!cmd_valid && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_seen"}, 32'(cmd_valid), 32'd1);
        chk({tag, "_type"}, 32'(cmd_type), 32'(typ));
        at = cyc;
    endtask

    initial begin
        int acc, acc2, t_act, t_rd, t_pre, t_g, exp_c, hits;
        rst = 1'b1; cmd_gnt = 1'b0; req_valid = 1'b0;
        req_id = '0; req_ra = '0; req_ca = '0; req_len = '0; req_wr = 1'b0;
        repeat (3) step();
        chk("rst_ready",    32'(req_ready), 32'd0);
        chk("rst_cmd_vld",  32'(cmd_valid), 32'd0);
        chk("rst_cmd_type", 32'(cmd_type),  32'd0);
        chk("rst_cmd_ra",   32'(cmd_ra),    32'd0);
        chk("rst_row_open", 32'(row_open),  32'd0);
        chk("rst_open_ra",  32'(open_ra),   32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        cmd_gnt = 1'b1;

        // First read to row 0x12: ACT two cycles after accept, RD tRCD later
        send_req("a", 5, 32'h12, 32'h40, 3, 1'b0, acc);
        wait_cmd("a_act", ACT, t_act);
        chk("a_act_cyc", 32'(t_act), 32'(acc + 2));
        chk("a_act_ra",  32'(cmd_ra), 32'h12);
        step();
        wait_cmd("a_rd", RD, t_rd);
        chk("a_rd_cyc",   32'(t_rd), 32'(t_act + T_RCD));
        chk("a_rd_ca",    32'(cmd_ca), 32'h40);
        chk("a_rd_len",   32'(cmd_len), 32'd3);
        chk("a_rd_id",    32'(cmd_id), 32'd5);
        chk("a_row_open", 32'(row_open), 32'd1);
        chk("a_open_ra",  32'(open_ra), 32'h12);
        step();
`ifdef SAL_BK_OPEN_PAGE_EN
        // Row hit: RD only, two cycles after acceptance
        send_req("b", 6, 32'h12, 32'h44, 1, 1'b0, acc2);
        wait_cmd("b_rd", RD, t_rd);
        chk("b_rd_cyc", 32'(t_rd), 32'(acc2 + 2));
        chk("b_rd_ca",  32'(cmd_ca), 32'h44);
        step();
        // Row miss: PRE gated by tRAS from the first ACT, then ACT after tRP
        send_req("c", 7, 32'h13, 32'h8, 2, 1'b0, acc2);
        wait_cmd("c_pre", PRE, t_pre);
        chk("c_pre_cyc", 32'(t_pre), 32'(t_act + T_RAS));
        chk("c_pre_ra",  32'(cmd_ra), 32'h12);
        step();
        wait_cmd("c_act", ACT, t_act);
        chk("c_act_cyc", 32'(t_act), 32'(t_pre + T_RP));
        chk("c_act_ra",  32'(cmd_ra), 32'h13);
        step();
        wait_cmd("c_rd", RD, t_rd);
        chk("c_rd_cyc", 32'(t_rd), 32'(t_act + T_RCD));
        step();
        // Another miss leaves the bank in CLOSING with a request pending
        send_req("d", 8, 32'h14, 32'h0, 0, 1'b0, acc2);
        step();
`else
        // Closed page: PRE once both tRAS (from ACT) and tRTP (from RD) allow
        wait_cmd("a_pre", PRE, t_pre);
        exp_c = (t_act + T_RAS > t_rd + T_RTP) ? t_act + T_RAS : t_rd + T_RTP;
        chk("a_pre_cyc", 32'(t_pre), 32'(exp_c));
        chk("a_pre_ra",  32'(cmd_ra), 32'h12);
        step();
        chk("a_row_closed", 32'(row_open), 32'd0);
        // Write right after PRE: ACT waits tRP, WR grant delayed three cycles
        send_req("b", 9, 32'h13, 32'h1, 7, 1'b1, acc);
        wait_cmd("b_act", ACT, t_act);
        chk("b_act_cyc", 32'(t_act), 32'(t_pre + T_RP));
        step();
        cmd_gnt = 1'b0;
        wait_cmd("b_wr", WR, t_rd);
        chk("b_wr_cyc", 32'(t_rd), 32'(t_act + T_RCD));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b_hold_vld",  32'(cmd_valid), 32'd1);
            chk("b_hold_type", 32'(cmd_type), 32'(WR));
            chk("b_hold_ra",   32'(cmd_ra), 32'h13);
        end
        cmd_gnt = 1'b1;
        t_g = cyc;
        step();
        wait_cmd("b_pre", PRE, t_pre);
        exp_c = (t_act + T_RAS > t_g + T_WR) ? t_act + T_RAS : t_g + T_WR;
        chk("b_pre_cyc", 32'(t_pre), 32'(exp_c));
        chk("b_pre_ra",  32'(cmd_ra), 32'h13);
        step();
        // Read, then queue another request while the bank is closing
        send_req("c", 3, 32'h20, 32'h10, 1, 1'b0, acc);
        wait_cmd("c_act", ACT, t_act);
        step();
        wait_cmd("c_rd", RD, t_rd);
        chk("c_rd_cyc", 32'(t_rd), 32'(t_act + T_RCD));
        step();
        send_req("d", 4, 32'h21, 32'h0, 0, 1'b0, acc2);
`endif
        // Reset pulse with a request pending in CLOSING aborts everything
        chk("d_pend_ready", 32'(req_ready), 32'd0);
        chk("d_row_open",   32'(row_open), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_cmd_vld",  32'(cmd_valid), 32'd0);
        chk("abort_row_open", 32'(row_open), 32'd0);
        chk("abort_ready",    32'(req_ready), 32'd1);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (cmd_valid) hits++;
        end
        chk("abort_no_cmd", 32'(hits), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
